vip_cheshire_uart_rx: RTL and testbench
=======================================

Name: vip_cheshire_uart_rx

Overview:
- Simulation-side UART receiver that consumes the SoC's `uart_tx` line inside the Cheshire VIP.
- Decodes 8N1 frames, sampled at mid-bit, into a byte stream.
- Buffers decoded bytes in a small FIFO and hands them out over valid/ready, for console printing and end-of-test string matching.
- Flags framing errors and FIFO overflow.

Parameters:
- ClkPerBit, 16, clock cycles per UART bit; must be ≥ 4.
- FifoDepth, 8, receive FIFO entries; power of two, ≥ 2.
- CntWidth, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  VIP clock, same clock as the DUT `clk_i`
- rst_i  in  1  asynchronous active-high reset
- uart_rx_i  in  1  serial line, driven by the DUT UART TX; idles high
- byte_o  out  8  head-of-FIFO data byte
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts; pop happens when valid_o && ready_i
- busy_o  out  1  FSM not in IDLE
- frame_err_o  out  1  one-cycle pulse when a stop bit samples low
- parity_err_o  out  1  one-cycle pulse on parity mismatch; tied 0 unless the optional feature is enabled
- overflow_o  out  1  one-cycle pulse when a byte is dropped because the FIFO is full
- drop_cnt_o  out  CntWidth  saturating count of dropped bytes

Behaviour:
- Reset values: all outputs 0; synchronizer flops 1; FSM in IDLE; FIFO empty; bit counter 0.
- Reset is asynchronous: asserting it mid-frame aborts the frame immediately and discards FIFO contents.
- Input path: 2-flop synchronizer on uart_rx_i. A falling edge is a synced value of 0 with a previous synced value of 1.
- FSM states:
  - IDLE → START on a falling edge; cycle counter cleared.
  - START: sample when counter == ClkPerBit/2 − 1.
    - Sample 1: false start, return to IDLE, no pulse.
    - Sample 0: go to DATA, counter cleared, bit index 0.
  - DATA: sample every ClkPerBit cycles. Bits are LSB first, shifted into the data register. After bit 7 go to STOP (or to PARITY if enabled).
  - STOP: sample after ClkPerBit cycles.
    - Sample 1: push the byte (subject to the FIFO rules below), then IDLE.
    - Sample 0: frame_err_o pulses that cycle, no push, go to BREAK.
  - BREAK: stay until the synced line is 1, then IDLE. This prevents a spurious restart during a break condition.
- The counter resets to 0 on every sample; ClkPerBit/2 uses integer division.
- Latency: a pushed byte appears on byte_o with valid_o = 1 in the cycle after the stop-bit sample.
- FIFO:
  - Output is first-word registered.
  - Push while full without a pop in the same cycle: byte dropped, overflow_o pulses, drop_cnt_o increments and saturates at all-ones.
  - Push and pop in the same cycle while full: both succeed, nothing dropped.
  - Pop while empty is ignored.
  - Pointers are log2(FifoDepth) + 1 bits wide and wrap naturally.
- byte_o holds its value while valid_o && !ready_i.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: VIP_CHESHIRE_UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled after ClkPerBit cycles.
  - Parity is even: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, parity_err_o pulses at the parity sample and the byte is still pushed if the stop bit is valid.
  - A parity-enable input is not added; the format is fixed 8E1.
- Undefined: 8N1 frames; parity_err_o tied to 0.

Decomposition:
- Shared package vip_cheshire_uart_pkg:
  - rx_state_e enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - localparam UartDataBits = 8.
  - Function for the even-parity check.
- Sub-module vip_cheshire_uart_rx_fifo: parameters FifoDepth and data width. Ports push, pop, full, empty, data in/out.

Test Plan (ClkPerBit=16, FifoDepth=4):
- Single byte: send 0x55 in 8N1 with ready_i=1 → valid_o pulses one cycle with byte_o=0x55; no error pulses. The valid rises 1 cycle after the stop-bit sample, i.e. 2 (sync) + 8 + 9·16 + 1 cycles after the start edge.
- Glitch rejection: drive uart_rx_i low for 5 cycles, then high → FSM returns to IDLE; no push; busy_o is 0 again within ≤ 12 cycles.
- Framing error: send 0xA3 with the stop bit held low for 40 cycles → frame_err_o pulses once; FIFO remains empty; busy_o stays 1 until the line returns high.
- Overflow: ready_i=0, send 0x01..0x06 → FIFO holds 0x01..0x04; overflow_o pulses twice; drop_cnt_o=2. Then raise ready_i → pops in order 0x01, 0x02, 0x03, 0x04.
- Reset mid-frame: assert rst_i during bit 3 of 0xFF → all outputs return to 0 asynchronously. After release, 0x42 is received correctly.
- Parity (macro defined): send 0x07 with parity bit 0 → parity_err_o pulses and byte 0x07 is still delivered. Send 0x07 with parity bit 1 → no pulse.

Source files
------------

// File: rtl/vip_cheshire_uart_pkg.sv
// vip_cheshire_uart_pkg: shared types, constants and parity helper for the Cheshire VIP UART receiver.
// Contents: rx_state_e receiver FSM states, UartDataBits data bits per frame,
// even_parity_ok() even-parity check over data plus parity bit.
package vip_cheshire_uart_pkg;

    localparam int UartDataBits = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    function automatic logic even_parity_ok(input logic [UartDataBits-1:0] data, input logic par);
        return ~^{data, par};
    endfunction

endpackage

// File: rtl/vip_cheshire_uart_rx_fifo.sv
// vip_cheshire_uart_rx_fifo: receive FIFO with the head word presented straight from storage.
// Ports: clk_i/rst_i clock and async active-high reset; push_i/data_i write side;
// pop_i/data_o read side (data_o is 0 while empty); full_o/empty_o status.
// A push while full is accepted only if a pop happens in the same cycle.
module vip_cheshire_uart_rx_fifo #(
    parameter int FifoDepth = 8,
    parameter int DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = $clog2(FifoDepth);

    logic [DataWidth-1:0] r_mem [FifoDepth];
    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;
    logic                 w_push;
    logic                 w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = r_wptr == r_rptr;
    assign full_o  = (r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}};
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | pop_i);
    assign data_o  = empty_o ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= r_wptr + (AW+1)'(w_push);
            r_rptr <= r_rptr + (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/vip_cheshire_uart_rx.sv
// vip_cheshire_uart_rx: VIP UART receiver decoding the SoC uart_tx line into a buffered byte stream.
// Ports: clk_i/rst_i clock and async active-high reset; uart_rx_i serial line (idles high);
// byte_o/valid_o/ready_i FIFO head handshake; busy_o FSM not idle; frame_err_o, parity_err_o,
// overflow_o one-cycle error pulses; drop_cnt_o saturating dropped-byte count.
// Define VIP_CHESHIRE_UART_RX_PARITY_EN for fixed 8E1 frames; otherwise 8N1 and parity_err_o is 0.
module vip_cheshire_uart_rx
    import vip_cheshire_uart_pkg::*;
#(
    parameter int ClkPerBit = 16,
    parameter int FifoDepth = 8,
    parameter int CntWidth  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    uart_rx_i,
    output logic [UartDataBits-1:0] byte_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic                    frame_err_o,
    output logic                    parity_err_o,
    output logic                    overflow_o,
    output logic [CntWidth-1:0]     drop_cnt_o
);

    localparam int CW = $clog2(ClkPerBit);
    localparam int BW = $clog2(UartDataBits);
    localparam logic [CW-1:0] HalfLast = CW'(ClkPerBit / 2 - 1);
    localparam logic [CW-1:0] BitLast  = CW'(ClkPerBit - 1);
    localparam logic [BW-1:0] LastBit  = BW'(UartDataBits - 1);

`ifdef VIP_CHESHIRE_UART_RX_PARITY_EN
    localparam rx_state_e AfterData = PARITY;
    logic w_parity_err;
`else
    localparam rx_state_e AfterData = STOP;
`endif

    logic [1:0]              r_sync;
    logic                    r_prev;
    rx_state_e               r_state;
    rx_state_e               w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [BW-1:0]           r_bit;
    logic [BW-1:0]           w_bit_nxt;
    logic [UartDataBits-1:0] r_data;
    logic [UartDataBits-1:0] w_data_nxt;
    logic [CntWidth-1:0]     r_drop_cnt;
    logic                    w_rx;
    logic                    w_fall;
    logic                    w_bit_end;
    logic                    w_push;
    logic                    w_frame_err;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_overflow;

    assign w_rx      = r_sync[1];
    assign w_fall    = r_prev & ~w_rx;
    assign w_bit_end = r_cnt == BitLast;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_data_nxt  = r_data;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
`ifdef VIP_CHESHIRE_UART_RX_PARITY_EN
        w_parity_err = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) w_state_nxt = START;
            end
            START: begin
                if (r_cnt == HalfLast) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt  = '0;
                    w_data_nxt = {w_rx, r_data[UartDataBits-1:1]};
                    w_bit_nxt  = r_bit + 1'b1;
                    if (r_bit == LastBit) w_state_nxt = AfterData;
                end
            end
`ifdef VIP_CHESHIRE_UART_RX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt    = '0;
                    w_parity_err = ~even_parity_ok(r_data, w_rx);
                    w_state_nxt  = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_push      = w_rx;
                    w_frame_err = ~w_rx;
                    w_state_nxt = w_rx ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Hold off until the line recovers so a long low is not seen as a new start bit.
                w_cnt_nxt = '0;
                if (w_rx) w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync     <= 2'b11;
            r_prev     <= 1'b1;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_data     <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_sync  <= {r_sync[0], uart_rx_i};
            r_prev  <= w_rx;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_data  <= w_data_nxt;
            if (w_overflow && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    vip_cheshire_uart_rx_fifo #(
        .FifoDepth (FifoDepth),
        .DataWidth (UartDataBits)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (ready_i),
        .data_i  (w_data_nxt),
        .data_o  (byte_o),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // A full FIFO always has valid_o high, so ready_i alone means a pop frees a slot this cycle.
    assign w_overflow  = w_push & w_full & ~ready_i;
    assign valid_o     = ~w_empty;
    assign busy_o      = r_state != IDLE;
    assign frame_err_o = w_frame_err;
    assign overflow_o  = w_overflow;
    assign drop_cnt_o  = r_drop_cnt;
`ifdef VIP_CHESHIRE_UART_RX_PARITY_EN
    assign parity_err_o = w_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vip_cheshire_uart_rx.sv
// tb_vip_cheshire_uart_rx: self-checking bench for vip_cheshire_uart_rx with a queue-based reference model.
module tb_vip_cheshire_uart_rx;

    localparam int Cpb   = 16;
    localparam int Depth = 4;
`ifdef VIP_CHESHIRE_UART_RX_PARITY_EN
    localparam int ParBits = 1;
`else
    localparam int ParBits = 0;
`endif
    localparam int Lat = 2 + Cpb / 2 + (9 + ParBits) * Cpb + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uart_rx = 1'b1;
    logic        ready = 1'b0;
    logic [7:0]  byte_o;
    logic        valid;
    logic        busy;
    logic        ferr;
    logic        perr;
    logic        ovf;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_ovf = 0;
    int n_vcyc = 0;
    logic pv = 1'b0;
    logic [7:0] rxq[$];

    vip_cheshire_uart_rx #(
        .ClkPerBit (Cpb),
        .FifoDepth (Depth),
        .CntWidth  (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .uart_rx_i    (uart_rx),
        .byte_o       (byte_o),
        .valid_o      (valid),
        .ready_i      (ready),
        .busy_o       (busy),
        .frame_err_o  (ferr),
        .parity_err_o (perr),
        .overflow_o   (ovf),
        .drop_cnt_o   (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && ready) rxq.push_back(byte_o);
        if (valid && !pv) rise_cyc = cyc;
        pv = valid;
        if (valid) n_vcyc++;
        if (ferr) n_ferr++;
        if (perr) n_perr++;
        if (ovf) n_ovf++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_len, input logic bad_par);
        uart_rx = 1'b0;
        tick(Cpb);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            tick(Cpb);
        end
        if (ParBits != 0) begin
            uart_rx = (^d) ^ bad_par;
            tick(Cpb);
        end
        uart_rx = stop_lvl;
        tick(stop_len);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte"}, 32'(byte_o), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ferr"}, 32'(ferr), 0);
        check({tag, "_perr"}, 32'(perr), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_drop"}, 32'(drop_cnt), 0);
    endtask

    initial begin
        int base, c0, f0, o0, v0, p0, k, drops, gap;
        logic [7:0] d;
        logic [7:0] mq[$];
        logic [7:0] exq[$];

        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        tick(3);
        rst = 1'b0;
        tick(4);

        // Single byte with latency measured from the start-bit edge.
        ready = 1'b1;
        base = rxq.size(); f0 = n_ferr; o0 = n_ovf; v0 = n_vcyc; c0 = cyc;
        send_frame(8'h55, 1'b1, Cpb, 1'b0);
        tick(4);
        check("single_latency", rise_cyc - c0, Lat);
        check("single_count", rxq.size() - base, 1);
        check("single_byte", 32'(rxq[base]), 'h55);
        check("single_valid_cycles", n_vcyc - v0, 1);
        check("single_ferr", n_ferr - f0, 0);
        check("single_ovf", n_ovf - o0, 0);

        // Short low glitch is a false start.
        base = rxq.size(); f0 = n_ferr;
        uart_rx = 1'b0;
        tick(5);
        check("glitch_busy_high", 32'(busy), 1);
        uart_rx = 1'b1;
        k = 0;
        while (busy && k < 12) begin
            tick(1);
            k++;
        end
        check("glitch_busy_low", 32'(busy), 0);
        tick(2 * Cpb);
        check("glitch_no_push", rxq.size() - base, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);

        // Stop bit held low: framing error, then break until the line returns high.
        base = rxq.size(); f0 = n_ferr;
        send_frame(8'hA3, 1'b0, 40, 1'b0);
        check("frame_busy_break", 32'(busy), 1);
        uart_rx = 1'b1;
        tick(4);
        check("frame_busy_idle", 32'(busy), 0);
        check("frame_err_pulses", n_ferr - f0, 1);
        check("frame_fifo_empty", 32'(valid), 0);
        check("frame_no_push", rxq.size() - base, 0);

        // Overflow: the model FIFO keeps the first Depth bytes and counts the rest as drops.
        ready = 1'b0;
        o0 = n_ovf; drops = 0;
        for (int b = 1; b <= 6; b++) begin
            d = 8'(b);
            if (mq.size() < Depth) mq.push_back(d);
            else drops++;
            send_frame(d, 1'b1, Cpb, 1'b0);
        end
        tick(4);
        check("ovf_pulses", n_ovf - o0, drops);
        check("ovf_drop_cnt", 32'(drop_cnt), drops);
        check("ovf_valid", 32'(valid), 1);
        check("ovf_head", 32'(byte_o), 32'(mq[0]));
        tick(7);
        check("ovf_head_hold", 32'(byte_o), 32'(mq[0]));
        base = rxq.size();
        ready = 1'b1;
        tick(Depth + 4);
        check("ovf_pop_count", rxq.size() - base, mq.size());
        for (int i = 0; i < mq.size(); i++) check("ovf_pop_order", 32'(rxq[base + i]), 32'(mq[i]));
        check("ovf_drained", 32'(valid), 0);

        // Asynchronous reset in the middle of a frame, with a byte waiting in the FIFO.
        ready = 1'b0;
        send_frame(8'h99, 1'b1, Cpb, 1'b0);
        tick(2);
        check("rst_pre_valid", 32'(valid), 1);
        uart_rx = 1'b0;
        tick(Cpb);
        for (int i = 0; i < 3; i++) begin
            uart_rx = 1'b1;
            tick(Cpb);
        end
        tick(5);
        check("rst_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        #2 check_reset_outputs("rst_mid");
        tick(1);
        uart_rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        ready = 1'b1;
        base = rxq.size();
        send_frame(8'h42, 1'b1, Cpb, 1'b0);
        tick(4);
        check("rst_after_count", rxq.size() - base, 1);
        check("rst_after_byte", 32'(rxq[base]), 'h42);

        // Random bytes with random idle gaps; every byte must come out in order.
        base = rxq.size(); f0 = n_ferr;
        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 20);
            exq.push_back(d);
            send_frame(d, 1'b1, Cpb, 1'b0);
            tick(gap);
        end
        tick(4);
        check("rand_count", rxq.size() - base, exq.size());
        for (int i = 0; i < exq.size(); i++) check("rand_byte", 32'(rxq[base + i]), 32'(exq[i]));
        check("rand_no_ferr", n_ferr - f0, 0);
        check("rand_no_drop", 32'(drop_cnt), 0);

`ifdef VIP_CHESHIRE_UART_RX_PARITY_EN
        base = rxq.size(); p0 = n_perr;
        send_frame(8'h07, 1'b1, Cpb, 1'b1);
        tick(4);
        check("par_bad_pulse", n_perr - p0, 1);
        check("par_bad_byte", 32'(rxq[base]), 'h07);
        send_frame(8'h07, 1'b1, Cpb, 1'b0);
        tick(4);
        check("par_good_no_pulse", n_perr - p0, 1);
        check("par_good_byte", 32'(rxq[base + 1]), 'h07);
`else
        p0 = 0;
        check("par_tied_low", n_perr - p0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
